// File: rtl/router_in_port.sv
// router_in_port
//   Per-input flit buffer with dimension-order route compute for a 3x3 torus
//   with four sub-layers. Each accepted flit gets its output direction
//   computed on entry and is queued in a small FIFO as {addr, route}. The
//   head entry is presented to the crossbar schedulers as a one-hot request,
//   and a grant pops it. A flit whose x or y field is 3 completes the
//   handshake but is discarded, and drop_err pulses for one cycle.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-high
//   in_valid  upstream flit valid
//   in_addr   upstream flit destination address {x[5:4], y[3:2], layer[1:0]}
//   in_ready  FIFO can accept a flit (count < DEPTH), combinational
//   req       one-hot direction of the head flit: 0=X+ 1=X- 2=Y+ 3=Y- 4=layer 5=local
//   req_addr  head flit address; zero when the FIFO is empty
//   grant     scheduler accepted the head flit this cycle
//   drop_err  one-cycle pulse after an illegal flit was accepted and discarded
//   count     current FIFO occupancy, 0..DEPTH
module router_in_port #(
  parameter int DEPTH  = 4,
  parameter int AW     = 6,
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0,
  parameter int NODE_L = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_addr,
  output logic                     in_ready,
  output logic [5:0]               req,
  output logic [AW-1:0]            req_addr,
  input  logic                     grant,
  output logic                     drop_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [1:0]    NX      = 2'(NODE_X);
  localparam logic [1:0]    NY      = 2'(NODE_Y);
  localparam logic [1:0]    NL      = 2'(NODE_L);

  // (a - b) mod 3 for coordinates in 0..2
  function automatic logic [1:0] mod3_diff(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] t;
    t = {1'b0, a} + 3'd3 - {1'b0, b};
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

  // Dimension order: X first, then Y, then sub-layer, else deliver locally.
  function automatic logic [5:0] route_of(input logic [AW-1:0] a);
    logic [1:0] dx;
    logic [1:0] dy;
    logic [5:0] r;
    dx = mod3_diff(a[5:4], NX);
    dy = mod3_diff(a[3:2], NY);
    r  = '0;
    if (dx == 2'd1)        r[0] = 1'b1;
    else if (dx == 2'd2)   r[1] = 1'b1;
    else if (dy == 2'd1)   r[2] = 1'b1;
    else if (dy == 2'd2)   r[3] = 1'b1;
    else if (a[1:0] != NL) r[4] = 1'b1;
    else                   r[5] = 1'b1;
    return r;
  endfunction

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [AW+5:0]   mem [DEPTH];
  logic [AW+5:0]   head;
  logic            empty;

  // Stage p0: handshake and route compute on the incoming flit
  logic            push_p0;
  logic            legal_p0;
  logic            write_p0;
  logic            pop_p0;
  logic [5:0]      route_p0;

  assign in_ready = (count != FULL_C);
  assign empty    = (count == '0);
  assign push_p0  = in_valid && in_ready;
  assign legal_p0 = (in_addr[5:4] != 2'b11) && (in_addr[3:2] != 2'b11);
  assign write_p0 = push_p0 && legal_p0;
  assign pop_p0   = grant && !empty;
  assign route_p0 = route_of(in_addr);

  assign head     = mem[rd_ptr];
  assign req      = empty ? '0 : head[5:0];
  assign req_addr = empty ? '0 : head[AW+5:6];

  // Stage p1: FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (write_p0) mem[wr_ptr] <= {in_addr, route_p0};
  end

  // Stage p1: pointers, occupancy and drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= push_p0 && !legal_p0;
      if (write_p0) wr_ptr <= wr_ptr + PONE_C;
      if (pop_p0)   rd_ptr <= rd_ptr + PONE_C;
      case ({write_p0, pop_p0})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_router_in_port.sv
module tb_router_in_port;

  localparam int NX = 0;
  localparam int NY = 0;
  localparam int NL = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_addr;
  logic       in_ready;
  logic [5:0] req;
  logic [5:0] req_addr;
  logic       grant;
  logic       drop_err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0] addr;
    logic [5:0] route;
  } exp_t;

  exp_t sb[$];

  router_in_port #(.DEPTH(4), .AW(6), .NODE_X(NX), .NODE_Y(NY), .NODE_L(NL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_ready(in_ready),
    .req(req), .req_addr(req_addr), .grant(grant), .drop_err(drop_err), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] model_route(input logic [5:0] a);
    int x, y, l, dx, dy;
    x  = int'(a[5:4]);
    y  = int'(a[3:2]);
    l  = int'(a[1:0]);
    dx = (x - NX + 3) % 3;
    dy = (y - NY + 3) % 3;
    if (dx == 1) return 6'b000001;
    if (dx == 2) return 6'b000010;
    if (dy == 1) return 6'b000100;
    if (dy == 2) return 6'b001000;
    if (l != NL) return 6'b010000;
    return 6'b100000;
  endfunction

  // Drive one flit for one cycle; records it in the scoreboard if it was accepted and legal.
  task automatic push_one(input logic [5:0] a, output bit acc);
    exp_t e;
    in_valid = 1'b1;
    in_addr  = a;
    acc      = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (acc && a[5:4] != 2'b11 && a[3:2] != 2'b11) begin
      e.addr  = a;
      e.route = model_route(a);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; grant = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (req !== 6'd0) begin bad++; $display("FAIL reset_req got=%b exp=000000", req); end
    total++; if (req_addr !== 6'd0) begin bad++; $display("FAIL reset_req_addr got=%h exp=00", req_addr); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    push_one(6'h10, acc);
    push_one(6'h04, acc);
    push_one(6'h00, acc);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL midrst_prefill got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
    total++; if (req !== 6'd0) begin bad++; $display("FAIL midrst_req got=%b exp=000000", req); end
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL midrst_drop got=%b exp=0", drop_err); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count_after got=%0d exp=0", count); end
  endtask

  task automatic test_route;
    logic [5:0] addrs [7];
    bit acc;
    exp_t e;
    addrs = '{6'h10, 6'h20, 6'h04, 6'h02, 6'h00, 6'h16, 6'h0A};
    for (int i = 0; i < 7; i++) begin
      total++; if (req !== 6'd0) begin bad++; $display("FAIL route_pre_empty got=%b exp=000000", req); end
      push_one(addrs[i], acc);
      e = sb[0];
      total++; if (req !== e.route) begin bad++; $display("FAIL route_req addr=%h got=%b exp=%b", addrs[i], req, e.route); end
      total++; if (req_addr !== e.addr) begin bad++; $display("FAIL route_req_addr got=%h exp=%h", req_addr, e.addr); end
      grant = 1'b1;
      @(negedge clk);
      grant = 1'b0;
      void'(sb.pop_front());
      total++; if (count !== 3'd0) begin bad++; $display("FAIL route_count_after_pop got=%0d exp=0", count); end
    end
  endtask

  task automatic test_full;
    logic [5:0] addrs [4];
    bit acc;
    exp_t e;
    addrs = '{6'h11, 6'h22, 6'h05, 6'h09};
    for (int i = 0; i < 4; i++) begin
      push_one(addrs[i], acc);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL full_accept idx=%0d got=%b exp=1", i, acc); end
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
    // fifth flit held by upstream while full; a pop in the same cycle must not let it in
    in_valid = 1'b1; in_addr = 6'h18; grant = 1'b1;
    e = sb[0];
    total++; if (req_addr !== e.addr) begin bad++; $display("FAIL full_head got=%h exp=%h", req_addr, e.addr); end
    @(negedge clk);
    grant = 1'b0;
    void'(sb.pop_front());
    total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%b exp=1", in_ready); end
    e.addr = 6'h18; e.route = model_route(6'h18);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_refill_count got=%0d exp=4", count); end
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      e = sb[0];
      total++; if (req_addr !== e.addr || req !== e.route) begin bad++; $display("FAIL full_drain got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
      grant = 1'b1;
      @(negedge clk);
      void'(sb.pop_front());
    end
    grant = 1'b0;
    total++; if (count !== 3'd0 || req !== 6'd0) begin bad++; $display("FAIL full_empty got=%0d/%b exp=0/000000", count, req); end
  endtask

  task automatic test_simul;
    logic [5:0] nxt [3];
    bit acc;
    exp_t e, n;
    nxt = '{6'h21, 6'h15, 6'h03};
    push_one(6'h24, acc);
    push_one(6'h08, acc);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_prefill got=%0d exp=2", count); end
    for (int i = 0; i < 3; i++) begin
      e = sb[0];
      total++; if (req_addr !== e.addr || req !== e.route) begin bad++; $display("FAIL simul_order got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
      in_valid = 1'b1; in_addr = nxt[i]; grant = 1'b1;
      n.addr = nxt[i]; n.route = model_route(nxt[i]);
      sb.push_back(n);
      @(negedge clk);
      in_valid = 1'b0; grant = 1'b0;
      void'(sb.pop_front());
      total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
    end
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      e = sb[0];
      total++; if (req_addr !== e.addr || req !== e.route) begin bad++; $display("FAIL simul_drain got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
      grant = 1'b1;
      @(negedge clk);
      void'(sb.pop_front());
    end
    grant = 1'b0;
  endtask

  task automatic test_illegal;
    bit acc;
    exp_t e;
    push_one(6'h14, acc);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL illegal_pre_drop got=%b exp=0", drop_err); end
    push_one(6'h30, acc);
    e = sb[0];
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL illegal_accept got=%b exp=1", acc); end
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL illegal_drop_x got=%b exp=1", drop_err); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL illegal_count got=%0d exp=1", count); end
    total++; if (req !== e.route || req_addr !== e.addr) begin bad++; $display("FAIL illegal_head got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
    @(negedge clk);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL illegal_pulse_width got=%b exp=0", drop_err); end
    push_one(6'h0C, acc);
    total++; if (drop_err !== 1'b1) begin bad++; $display("FAIL illegal_drop_y got=%b exp=1", drop_err); end
    push_one(6'h29, acc);
    total++; if (drop_err !== 1'b0) begin bad++; $display("FAIL illegal_drop_clear got=%b exp=0", drop_err); end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL illegal_legal_after got=%0d exp=2", count); end
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      e = sb[0];
      total++; if (req_addr !== e.addr || req !== e.route) begin bad++; $display("FAIL illegal_drain got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
      grant = 1'b1;
      @(negedge clk);
      void'(sb.pop_front());
    end
    grant = 1'b0;
  endtask

  task automatic test_spurious;
    bit acc;
    exp_t e;
    grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++; if (count !== 3'd0 || req !== 6'd0) begin bad++; $display("FAIL spur_empty got=%0d/%b exp=0/000000", count, req); end
    end
    grant = 1'b0;
    push_one(6'h25, acc);
    e = sb[0];
    total++; if (count !== 3'd1) begin bad++; $display("FAIL spur_count got=%0d exp=1", count); end
    total++; if (req !== e.route || req_addr !== e.addr) begin bad++; $display("FAIL spur_head got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
    // hold without grant: request must stay put
    repeat (3) @(negedge clk);
    total++; if (req !== e.route || req_addr !== e.addr) begin bad++; $display("FAIL spur_hold got=%h/%b exp=%h/%b", req_addr, req, e.addr, e.route); end
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    void'(sb.pop_front());
    total++; if (count !== 3'd0 || req !== 6'd0) begin bad++; $display("FAIL spur_final got=%0d/%b exp=0/000000", count, req); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_full();
    test_simul();
    test_illegal();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
